// File: rtl/br_pkg.sv
// Shared decode constants, funct3/FSM enums and RV immediate extractors for the
// decode-stage branch resolver.
package br_pkg;

    localparam logic [6:0] BR_OP   = 7'b1100011;
    localparam logic [6:0] JAL_OP  = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } br_state_e;

    // Immediates come back sign-extended to 32 bits; callers widen to XLEN with a signed cast.
    function automatic logic signed [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic signed [31:0] i_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-side bundle of the branch resolver: ID inputs, MEM/WB forwarding,
// EX hazard info and the registered redirect. Stats ports exist only with BR_STATS_EN.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32,
    parameter int REGS = 32
);
    localparam int IW = $clog2(REGS);

    logic            id_valid;
    logic [31:0]     code_bus;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] rf_reg_s1;
    logic [XLEN-1:0] rf_reg_s2;
    logic [IW-1:0]   ex_rd;
    logic            ex_reg_write;
    logic [IW-1:0]   mem_rd;
    logic            mem_reg_write;
    logic            mem_is_load;
    logic [XLEN-1:0] mem_result;
    logic [IW-1:0]   wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;
    logic            flush;
    logic            br_stall;
    logic            br_valid;
    logic            branch;
    logic [XLEN-1:0] br_target;
`ifdef BR_STATS_EN
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_taken;
    logic [31:0]     stat_stall_cycles;
`endif

    modport master (
        output id_valid, code_bus, id_pc, rf_reg_s1, rf_reg_s2,
        output ex_rd, ex_reg_write, mem_rd, mem_reg_write, mem_is_load, mem_result,
        output wb_rd, wb_reg_write, wb_result, flush,
        input  br_stall, br_valid, branch, br_target
`ifdef BR_STATS_EN
        , input stat_resolved, stat_taken, stat_stall_cycles
`endif
    );

    modport slave (
        input  id_valid, code_bus, id_pc, rf_reg_s1, rf_reg_s2,
        input  ex_rd, ex_reg_write, mem_rd, mem_reg_write, mem_is_load, mem_result,
        input  wb_rd, wb_reg_write, wb_result, flush,
        output br_stall, br_valid, branch, br_target
`ifdef BR_STATS_EN
        , output stat_resolved, stat_taken, stat_stall_cycles
`endif
    );

endinterface

// File: rtl/br_fwd_mux.sv
// Per-source operand picker: x0 / MEM / WB / RF, plus the hazard bit for a
// producer whose value cannot be forwarded yet (EX result, MEM load).
module br_fwd_mux #(
    parameter int XLEN = 32,
    parameter int IW   = 5
) (
    input  logic [IW-1:0]   idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic [IW-1:0]   ex_rd,
    input  logic            ex_reg_write,
    input  logic [IW-1:0]   mem_rd,
    input  logic            mem_reg_write,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_result,
    input  logic [IW-1:0]   wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] operand,
    output logic            hazard
);

    always_comb begin
        operand = rf_data;
        hazard  = 1'b0;
        if (idx == '0) begin
            operand = '0;
        end else begin
            if (mem_reg_write && (mem_rd == idx) && !mem_is_load)
                operand = mem_result;
            else if (wb_reg_write && (wb_rd == idx))
                operand = wb_result;
            hazard = (ex_reg_write && (ex_rd == idx)) ||
                     (mem_reg_write && mem_is_load && (mem_rd == idx));
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch/JAL/JALR resolver with MEM/WB forwarding and hazard stall;
// redirect outputs are registered. Optional BR_STATS_EN adds saturating event counters.
//
// state | meaning
// RUN   | no hazard outstanding; resolve control flow as it arrives
// STALL | waiting for a needed operand from EX or a MEM load
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGS = 32
) (
    input logic clk,
    input logic rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int IW = $clog2(REGS);

    logic [6:0]      opcode;
    br_funct3_e      funct3;
    logic            is_br, is_jal, is_jalr, is_cf;
    logic [IW-1:0]   rs1_idx, rs2_idx;
    logic [XLEN-1:0] op1, op2;
    logic            haz1, haz2, hazard, stall, resolve;
    logic            taken;
    logic [XLEN-1:0] jalr_sum, target;

    br_state_e       state_d, state_q;
    logic            br_valid_d, br_valid_q;
    logic            branch_d, branch_q;
    logic [XLEN-1:0] br_target_d, br_target_q;

    assign opcode  = bus.code_bus[6:0];
    assign funct3  = br_funct3_e'(bus.code_bus[14:12]);
    assign is_br   = (opcode == BR_OP);
    assign is_jal  = (opcode == JAL_OP);
    assign is_jalr = (opcode == JALR_OP);
    assign is_cf   = is_br | is_jal | is_jalr;
    assign rs1_idx = IW'(bus.code_bus[19:15]);
    assign rs2_idx = IW'(bus.code_bus[24:20]);

    br_fwd_mux #(.XLEN(XLEN), .IW(IW)) u_fwd_rs1 (
        .idx(rs1_idx), .rf_data(bus.rf_reg_s1),
        .ex_rd(bus.ex_rd), .ex_reg_write(bus.ex_reg_write),
        .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write),
        .mem_is_load(bus.mem_is_load), .mem_result(bus.mem_result),
        .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_result(bus.wb_result),
        .operand(op1), .hazard(haz1)
    );

    br_fwd_mux #(.XLEN(XLEN), .IW(IW)) u_fwd_rs2 (
        .idx(rs2_idx), .rf_data(bus.rf_reg_s2),
        .ex_rd(bus.ex_rd), .ex_reg_write(bus.ex_reg_write),
        .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write),
        .mem_is_load(bus.mem_is_load), .mem_result(bus.mem_result),
        .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_result(bus.wb_result),
        .operand(op2), .hazard(haz2)
    );

    // JAL reads no register, JALR only rs1; the rs2 field of JALR is immediate bits.
    assign hazard  = ((is_br | is_jalr) & haz1) | (is_br & haz2);
    assign stall   = bus.id_valid & ~bus.flush & hazard;
    assign resolve = bus.id_valid & ~bus.flush & ~stall & is_cf;
    assign bus.br_stall = stall;

    always_comb begin
        taken = 1'b0;
        if (is_jal || is_jalr) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                BEQ:     taken = (op1 == op2);
                BNE:     taken = (op1 != op2);
                BLT:     taken = ($signed(op1) < $signed(op2));
                BGE:     taken = !($signed(op1) < $signed(op2));
                BLTU:    taken = (op1 < op2);
                BGEU:    taken = !(op1 < op2);
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        jalr_sum = op1 + XLEN'(i_imm(bus.code_bus));
        if (is_jalr)
            target = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_jal)
            target = bus.id_pc + XLEN'(j_imm(bus.code_bus));
        else
            target = bus.id_pc + XLEN'(b_imm(bus.code_bus));
    end

    always_comb begin
        state_d     = RUN;
        br_valid_d  = resolve;
        branch_d    = resolve & taken;
        br_target_d = resolve ? target : br_target_q;
        if (!bus.flush && stall)
            state_d = STALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            br_valid_q  <= 1'b0;
            branch_q    <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            br_valid_q  <= br_valid_d;
            branch_q    <= branch_d;
            br_target_q <= br_target_d;
        end
    end

    assign bus.br_valid  = br_valid_q;
    assign bus.branch    = branch_q;
    assign bus.br_target = br_target_q;

`ifdef BR_STATS_EN
    logic [31:0] stat_resolved_d, stat_resolved_q;
    logic [31:0] stat_taken_d, stat_taken_q;
    logic [31:0] stat_stall_d, stat_stall_q;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_taken_d    = stat_taken_q;
        stat_stall_d    = stat_stall_q;
        if (resolve && (stat_resolved_q != '1))
            stat_resolved_d = stat_resolved_q + 32'd1;
        if (resolve && taken && (stat_taken_q != '1))
            stat_taken_d = stat_taken_q + 32'd1;
        if (stall && (stat_stall_q != '1))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q <= '0;
            stat_taken_q    <= '0;
            stat_stall_q    <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_taken_q    <= stat_taken_d;
            stat_stall_q    <= stat_stall_d;
        end
    end

    assign bus.stat_resolved     = stat_resolved_q;
    assign bus.stat_taken        = stat_taken_q;
    assign bus.stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: decode, signed/unsigned compares,
// forwarding, stalls, flush, reset and (with BR_STATS_EN) the counters.
module tb_branch_resolve_unit;
    import br_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   chk = 0;
    int   pass = 0;

    branch_resolve_unit_if #(.XLEN(32), .REGS(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_valid      = 1'b0;
        bus.code_bus      = 32'h0000_0013;
        bus.id_pc         = '0;
        bus.rf_reg_s1     = '0;
        bus.rf_reg_s2     = '0;
        bus.ex_rd         = '0;
        bus.ex_reg_write  = 1'b0;
        bus.mem_rd        = '0;
        bus.mem_reg_write = 1'b0;
        bus.mem_is_load   = 1'b0;
        bus.mem_result    = '0;
        bus.wb_rd         = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_result     = '0;
        bus.flush         = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", bus.br_valid); else pass++;
        chk++; if (bus.branch !== 1'b0) $display("FAIL reset_branch got %0h exp 0", bus.branch); else pass++;
        chk++; if (bus.br_target !== 32'h0) $display("FAIL reset_target got %08h exp 0", bus.br_target); else pass++;
        chk++; if (dut.state_q !== RUN) $display("FAIL reset_state got %0h exp RUN", dut.state_q); else pass++;
    endtask

    task automatic test_beq();
        clear_in();
        bus.id_valid  = 1'b1;
        bus.code_bus  = enc_b(3'b000, 5'd1, 5'd2, 13'd16);
        bus.id_pc     = 32'h100;
        bus.rf_reg_s1 = 32'd5;
        bus.rf_reg_s2 = 32'd5;
        #1;
        chk++; if (bus.br_stall !== 1'b0) $display("FAIL beq_stall got %0h exp 0", bus.br_stall); else pass++;
        step();
        chk++; if (bus.br_valid !== 1'b1) $display("FAIL beq_valid got %0h exp 1", bus.br_valid); else pass++;
        chk++; if (bus.branch !== 1'b1) $display("FAIL beq_branch got %0h exp 1", bus.branch); else pass++;
        chk++; if (bus.br_target !== 32'h110) $display("FAIL beq_target got %08h exp 00000110", bus.br_target); else pass++;
        bus.id_valid = 1'b0;
        step();
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL idle_valid got %0h exp 0", bus.br_valid); else pass++;
        chk++; if (bus.br_target !== 32'h110) $display("FAIL idle_target_hold got %08h exp 00000110", bus.br_target); else pass++;
        // Not a control-flow opcode: nothing resolves.
        bus.id_valid = 1'b1;
        bus.code_bus = 32'h0010_8093;
        step();
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL addi_valid got %0h exp 0", bus.br_valid); else pass++;
    endtask

    task automatic test_signed();
        logic [2:0]  f3   [7] = '{3'b101, 3'b111, 3'b101, 3'b100, 3'b110, 3'b001, 3'b010};
        logic [31:0] a    [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] b    [7] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd5, 32'd6};
        logic        exp_t[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_in();
        bus.id_valid = 1'b1;
        bus.id_pc    = 32'h200;
        for (int i = 0; i < 7; i++) begin
            bus.code_bus  = enc_b(f3[i], 5'd1, 5'd2, 13'd8);
            bus.rf_reg_s1 = a[i];
            bus.rf_reg_s2 = b[i];
            step();
            chk++; if (bus.branch !== exp_t[i] || bus.br_valid !== 1'b1)
                $display("FAIL cmp_%0d valid=%0h branch=%0h exp valid=1 branch=%0h", i, bus.br_valid, bus.branch, exp_t[i]);
            else pass++;
        end
        chk++; if (bus.br_target !== 32'h208) $display("FAIL cmp_target got %08h exp 00000208", bus.br_target); else pass++;
    endtask

    task automatic test_stall_fwd();
        clear_in();
        bus.id_valid     = 1'b1;
        bus.code_bus     = enc_b(3'b001, 5'd3, 5'd0, 13'd4);
        bus.id_pc        = 32'h300;
        bus.ex_rd        = 5'd3;
        bus.ex_reg_write = 1'b1;
        #1;
        chk++; if (bus.br_stall !== 1'b1) $display("FAIL ex_haz_stall got %0h exp 1", bus.br_stall); else pass++;
        step();
        chk++; if (dut.state_q !== STALL) $display("FAIL ex_haz_state got %0h exp STALL", dut.state_q); else pass++;
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL ex_haz_valid got %0h exp 0", bus.br_valid); else pass++;
        bus.ex_reg_write  = 1'b0;
        bus.mem_rd        = 5'd3;
        bus.mem_reg_write = 1'b1;
        bus.mem_result    = 32'd7;
        #1;
        chk++; if (bus.br_stall !== 1'b0) $display("FAIL mem_fwd_stall got %0h exp 0", bus.br_stall); else pass++;
        step();
        chk++; if (bus.branch !== 1'b1 || bus.br_valid !== 1'b1)
            $display("FAIL mem_fwd_branch valid=%0h branch=%0h exp 1 1", bus.br_valid, bus.branch); else pass++;
        chk++; if (dut.state_q !== RUN) $display("FAIL mem_fwd_state got %0h exp RUN", dut.state_q); else pass++;
        chk++; if (bus.br_target !== 32'h304) $display("FAIL mem_fwd_target got %08h exp 00000304", bus.br_target); else pass++;
        bus.mem_is_load = 1'b1;
        #1;
        chk++; if (bus.br_stall !== 1'b1) $display("FAIL load_haz_stall got %0h exp 1", bus.br_stall); else pass++;
        // MEM must win over WB for the same register.
        bus.mem_is_load  = 1'b0;
        bus.code_bus     = enc_b(3'b000, 5'd3, 5'd4, 13'd4);
        bus.rf_reg_s2    = 32'd7;
        bus.wb_rd        = 5'd3;
        bus.wb_reg_write = 1'b1;
        bus.wb_result    = 32'd9;
        step();
        chk++; if (bus.branch !== 1'b1) $display("FAIL mem_over_wb got %0h exp 1", bus.branch); else pass++;
        // rs2 forwarded from WB.
        clear_in();
        bus.id_valid     = 1'b1;
        bus.code_bus     = enc_b(3'b000, 5'd1, 5'd6, 13'd4);
        bus.rf_reg_s1    = 32'd9;
        bus.wb_rd        = 5'd6;
        bus.wb_reg_write = 1'b1;
        bus.wb_result    = 32'd9;
        step();
        chk++; if (bus.branch !== 1'b1) $display("FAIL wb_fwd_rs2 got %0h exp 1", bus.branch); else pass++;
    endtask

    task automatic test_jumps();
        clear_in();
        bus.id_valid     = 1'b1;
        bus.code_bus     = enc_jalr(5'd1, 5'd5, 12'd2);
        bus.rf_reg_s1    = 32'h1234;
        bus.wb_rd        = 5'd5;
        bus.wb_reg_write = 1'b1;
        bus.wb_result    = 32'h2001;
        step();
        chk++; if (bus.br_target !== 32'h2002) $display("FAIL jalr_target got %08h exp 00002002", bus.br_target); else pass++;
        chk++; if (bus.branch !== 1'b1) $display("FAIL jalr_branch got %0h exp 1", bus.branch); else pass++;
        clear_in();
        bus.id_valid  = 1'b1;
        bus.code_bus  = enc_jalr(5'd0, 5'd0, 12'h100);
        bus.rf_reg_s1 = 32'hDEAD;
        step();
        chk++; if (bus.br_target !== 32'h100) $display("FAIL jalr_x0 got %08h exp 00000100", bus.br_target); else pass++;
        bus.code_bus = enc_j(5'd1, 21'h1FFFFC);
        bus.id_pc    = 32'h1000;
        step();
        chk++; if (bus.br_target !== 32'hFFC || bus.branch !== 1'b1)
            $display("FAIL jal_back target=%08h branch=%0h exp 00000ffc 1", bus.br_target, bus.branch); else pass++;
        bus.code_bus = enc_j(5'd1, 21'h20);
        bus.id_pc    = 32'hFFFF_FFF0;
        step();
        chk++; if (bus.br_target !== 32'h10) $display("FAIL jal_wrap got %08h exp 00000010", bus.br_target); else pass++;
    endtask

    task automatic test_flush_reset();
        clear_in();
        bus.id_valid     = 1'b1;
        bus.code_bus     = enc_b(3'b000, 5'd1, 5'd2, 13'd16);
        bus.ex_rd        = 5'd1;
        bus.ex_reg_write = 1'b1;
        step();
        chk++; if (dut.state_q !== STALL) $display("FAIL flush_pre_state got %0h exp STALL", dut.state_q); else pass++;
        bus.flush = 1'b1;
        #1;
        chk++; if (bus.br_stall !== 1'b0) $display("FAIL flush_stall got %0h exp 0", bus.br_stall); else pass++;
        step();
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL flush_valid got %0h exp 0", bus.br_valid); else pass++;
        chk++; if (dut.state_q !== RUN) $display("FAIL flush_state got %0h exp RUN", dut.state_q); else pass++;
        bus.flush = 1'b0;
        step();
        chk++; if (dut.state_q !== STALL) $display("FAIL rst_pre_state got %0h exp STALL", dut.state_q); else pass++;
        rst_n = 1'b0;
        #1;
        chk++; if (bus.br_valid !== 1'b0 || bus.branch !== 1'b0 || bus.br_target !== 32'h0)
            $display("FAIL rst_mid outputs valid=%0h branch=%0h target=%08h exp 0 0 0", bus.br_valid, bus.branch, bus.br_target);
        else pass++;
        chk++; if (dut.state_q !== RUN) $display("FAIL rst_mid_state got %0h exp RUN", dut.state_q); else pass++;
        clear_in();
        step();
        rst_n = 1'b1;
        step();
        chk++; if (bus.br_valid !== 1'b0) $display("FAIL rst_release_valid got %0h exp 0", bus.br_valid); else pass++;
    endtask

`ifdef BR_STATS_EN
    task automatic test_stats();
        chk++; if (bus.stat_resolved !== 32'd0) $display("FAIL stat_reset got %0d exp 0", bus.stat_resolved); else pass++;
        clear_in();
        bus.id_valid  = 1'b1;
        bus.rf_reg_s1 = 32'd5;
        bus.rf_reg_s2 = 32'd5;
        bus.code_bus  = enc_b(3'b000, 5'd1, 5'd2, 13'd8);
        step();
        bus.code_bus  = enc_b(3'b001, 5'd1, 5'd2, 13'd8);
        step();
        bus.code_bus     = enc_b(3'b000, 5'd1, 5'd2, 13'd8);
        bus.ex_rd        = 5'd2;
        bus.ex_reg_write = 1'b1;
        step(); step();
        bus.ex_reg_write = 1'b0;
        step();
        bus.id_valid = 1'b0;
        step();
        chk++; if (bus.stat_resolved !== 32'd3) $display("FAIL stat_resolved got %0d exp 3", bus.stat_resolved); else pass++;
        chk++; if (bus.stat_taken !== 32'd2) $display("FAIL stat_taken got %0d exp 2", bus.stat_taken); else pass++;
        chk++; if (bus.stat_stall_cycles !== 32'd2) $display("FAIL stat_stall got %0d exp 2", bus.stat_stall_cycles); else pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_in();
        test_reset();
        test_beq();
        test_signed();
        test_stall_fwd();
        test_jumps();
        test_flush_reset();
`ifdef BR_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
